note_detector: RTL

NOTE_DETECTOR -- requirements
Module: note_detector

---
 rtl/note_pkg.sv | 42 ++++
 rtl/period_classifier.sv | 22 ++
 rtl/note_detector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared timing constants and note table for the tone detector and tone generators.
package note_pkg;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned TIMEOUT   = CLK_FREQ / 200;   // 5 ms without an edge
  localparam int unsigned MS_DIV    = CLK_FREQ / 1000;  // clocks per millisecond
  localparam int unsigned PERIOD_W  = 18;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned NUM_NOTES = 7;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    NOTE_F    = 3'd1,
    NOTE_GS   = 3'd2,
    NOTE_A    = 3'd3,
    NOTE_CH   = 3'd4,
    NOTE_EH   = 3'd5,
    NOTE_FH   = 3'd6
  } note_t;

  // +/-1 % acceptance window around a nominal period
  function automatic int unsigned win_min(input int unsigned nom);
    return nom - nom / 100;
  endfunction

  function automatic int unsigned win_max(input int unsigned nom);
    return nom + nom / 100;
  endfunction

  // Full tone period in clocks, indexed by note_t
  localparam int unsigned PERIOD_NOM [NUM_NOTES] =
    '{0, 143266, 120482, 113636, 95602, 75872, 71633};

  localparam int unsigned PERIOD_MIN [NUM_NOTES] = '{
    0, win_min(PERIOD_NOM[1]), win_min(PERIOD_NOM[2]), win_min(PERIOD_NOM[3]),
    win_min(PERIOD_NOM[4]), win_min(PERIOD_NOM[5]), win_min(PERIOD_NOM[6])};

  localparam int unsigned PERIOD_MAX [NUM_NOTES] = '{
    0, win_max(PERIOD_NOM[1]), win_max(PERIOD_NOM[2]), win_max(PERIOD_NOM[3]),
    win_max(PERIOD_NOM[4]), win_max(PERIOD_NOM[5]), win_max(PERIOD_NOM[6])};

endpackage

// File: rtl/period_classifier.sv
// Combinational lookup: measured period in clocks -> note code (NOTE_NONE if no window matches).
module period_classifier
  import note_pkg::*;
#(
  // Divides every window by 2**PERIOD_SHIFT; 0 on real hardware
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input  logic [PERIOD_W-1:0] period,
  output note_t               code
);

  // Windows are disjoint, so at most one note can match
  always_comb begin
    code = NOTE_NONE;
    for (int unsigned i = 1; i < NUM_NOTES; i++) begin
      if (32'(period) >= (PERIOD_MIN[i] >> PERIOD_SHIFT) &&
          32'(period) <= (PERIOD_MAX[i] >> PERIOD_SHIFT))
        code = note_t'(i[2:0]);
    end
  end

endmodule

// File: rtl/note_detector.sv
// Detects which note is on the speaker line, reports lock/unlock pulses and note length in ms.
module note_detector
  import note_pkg::*;
#(
  parameter int unsigned PERIOD_SHIFT = 0,
  parameter int unsigned MS_DIV_CLKS  = MS_DIV
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  input  logic                 tone_in,
  output logic [2:0]           note_code,
  output logic                 note_valid,
  output logic                 note_start,
  output logic                 note_done,
  output logic [LEN_W-1:0]     note_len_ms
);

  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_SAT  = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT >> PERIOD_SHIFT);
  localparam logic [15:0]         PRESC_LAST  = 16'(MS_DIV_CLKS - 1);

  logic [2:0]          sync_q;
  logic                tone_d_q;
  logic                tone_rise;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] measured;
  logic                timeout;
  note_t               cls;

  state_t              state_q, state_d;
  note_t               cand_q, cand_d;
  note_t               code_q, code_d;
  logic                mis_q, mis_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic [15:0]         presc_q, presc_d;
  logic [LEN_W-1:0]    len_q, len_d;

  // Three-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sync_q   <= '0;
      tone_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], tone_in};
      tone_d_q <= sync_q[2];
    end
  end

  assign tone_rise = sync_q[2] & ~tone_d_q;

  // Clocks since the last rising edge, saturating
  always_ff @(posedge clk_50MHz) begin
    if (rst)
      period_q <= '0;
    else if (tone_rise)
      period_q <= '0;
    else if (period_q != PERIOD_SAT)
      period_q <= period_q + 1'b1;
  end

  // The edge cycle itself belongs to the period it closes
  assign measured = (period_q == PERIOD_SAT) ? PERIOD_SAT : period_q + 1'b1;
  assign timeout  = (period_q == TIMEOUT_CNT) && !tone_rise;

  period_classifier #(.PERIOD_SHIFT(PERIOD_SHIFT)) u_classifier (
    .period (measured),
    .code   (cls)
  );

  // FSM and output registers
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= SILENT;
      cand_q  <= NOTE_NONE;
      code_q  <= NOTE_NONE;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      start_q <= start_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic; code/valid drop one cycle after note_done so the done cycle still shows the ended note
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    code_d  = code_q;
    mis_d   = mis_q;
    valid_d = valid_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    presc_d = presc_q;
    len_d   = len_q;

    if (done_q) begin
      code_d  = NOTE_NONE;
      valid_d = 1'b0;
    end

    if (state_q == LOCKED) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (len_q != '1)
          len_d = len_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    unique case (state_q)
      SILENT: begin
        if (tone_rise) begin
          state_d = ACQUIRE;
          cand_d  = NOTE_NONE;
        end
      end
      ACQUIRE: begin
        if (tone_rise) begin
          if (cls != NOTE_NONE && cls == cand_q) begin
            state_d = LOCKED;
            code_d  = cls;
            valid_d = 1'b1;
            start_d = 1'b1;
            mis_d   = 1'b0;
            presc_d = '0;
            len_d   = '0;
          end else begin
            cand_d = cls;
          end
        end else if (timeout) begin
          state_d = SILENT;
        end
      end
      LOCKED: begin
        if (tone_rise) begin
          if (cls == code_q) begin
            mis_d = 1'b0;
          end else if (mis_q) begin
            done_d  = 1'b1;
            state_d = ACQUIRE;
            cand_d  = cls;
            mis_d   = 1'b0;
          end else begin
            mis_d = 1'b1;
          end
        end else if (timeout) begin
          done_d  = 1'b1;
          state_d = SILENT;
          mis_d   = 1'b0;
        end
      end
      default: state_d = SILENT;
    endcase
  end

  assign note_code   = code_q;
  assign note_valid  = valid_q;
  assign note_start  = start_q;
  assign note_done   = done_q;
  assign note_len_ms = len_q;

endmodule
